// File: rtl/coin_input_pkg.sv
// Shared types and defaults for the coin pushbutton front end.
package coin_input_pkg;

    // Default debounce length; small so simulation stays short.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } debounce_state_t;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_100,
        EV_500,
        EV_REJECT
    } coin_event_t;

endpackage

// File: rtl/button_debouncer_module.sv
// One pushbutton channel: 2-flop synchroniser, debounce FSM and stability
// counter. 'qualified' is high during the cycle whose rising edge moves the
// channel from PRESS_WAIT into HELD, once per physical press.
module button_debouncer_module
    import coin_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic qualified
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    debounce_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state, counter and qualification logic; only sync2_q is trusted.
    always_comb begin
        sync1_d   = button_raw;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        qualified = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    qualified = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and synchroniser registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/coin_input_module.sv
// Coin pushbutton front end: debounces both buttons, arbitrates same-edge
// presses (500 first, 100 deferred one cycle) and rejects coins under lockout.
module coin_input_module
    import coin_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic coin_100_raw,
    input  logic coin_500_raw,
    input  logic lockout,
    output logic coin_100,
    output logic coin_500,
    output logic coin_rejected
);

    logic        qual_100;
    logic        qual_500;
    coin_event_t cur_ev;
    coin_event_t pending_q, pending_d;
    logic        coin_100_q, coin_100_d;
    logic        coin_500_q, coin_500_d;
    logic        coin_rejected_q, coin_rejected_d;

    button_debouncer_module #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_100 (
        .clock     (clock),
        .reset     (reset),
        .button_raw(coin_100_raw),
        .qualified (qual_100)
    );

    button_debouncer_module #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_500 (
        .clock     (clock),
        .reset     (reset),
        .button_raw(coin_500_raw),
        .qualified (qual_500)
    );

    // Arbitration: lockout decides accept/reject on the qualifying edge; a
    // deferred 100 event is already decided and ignores later lockout.
    // Both channels sit in HELD while an event is pending, so no fresh
    // qualification can collide with it.
    always_comb begin
        cur_ev    = EV_NONE;
        pending_d = EV_NONE;
        if (pending_q != EV_NONE) begin
            cur_ev = pending_q;
        end else if (qual_500) begin
            cur_ev = lockout ? EV_REJECT : EV_500;
            if (qual_100) begin
                pending_d = lockout ? EV_REJECT : EV_100;
            end
        end else if (qual_100) begin
            cur_ev = lockout ? EV_REJECT : EV_100;
        end
        coin_100_d      = (cur_ev == EV_100);
        coin_500_d      = (cur_ev == EV_500);
        coin_rejected_d = (cur_ev == EV_REJECT);
    end

    // Registered one-hot output pulses and the pending event.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q       <= EV_NONE;
            coin_100_q      <= 1'b0;
            coin_500_q      <= 1'b0;
            coin_rejected_q <= 1'b0;
        end else begin
            pending_q       <= pending_d;
            coin_100_q      <= coin_100_d;
            coin_500_q      <= coin_500_d;
            coin_rejected_q <= coin_rejected_d;
        end
    end

    assign coin_100      = coin_100_q;
    assign coin_500      = coin_500_q;
    assign coin_rejected = coin_rejected_q;

endmodule

// File: tb/tb_coin_input_module.sv
// Directed bench for coin_input_module (DEBOUNCE_CYCLES = 4). Each scenario
// drives 32 cycles of per-edge input vectors (bit i = value before edge i)
// and records outputs after each edge as 32-bit traces (bit i = after edge i).
module tb_coin_input_module;

    logic clock;
    logic reset;
    logic coin_100_raw;
    logic coin_500_raw;
    logic lockout;
    logic coin_100;
    logic coin_500;
    logic coin_rejected;

    int unsigned total;
    int unsigned bad;

    logic [31:0] t100;
    logic [31:0] t500;
    logic [31:0] trej;

    coin_input_module #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .coin_100_raw (coin_100_raw),
        .coin_500_raw (coin_500_raw),
        .lockout      (lockout),
        .coin_100     (coin_100),
        .coin_500     (coin_500),
        .coin_rejected(coin_rejected)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold reset with buttons released, then leave inputs just before edge 0.
    task automatic reset_dut();
        coin_100_raw = 1'b0;
        coin_500_raw = 1'b0;
        lockout      = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_c100", {31'd0, coin_100}, 32'd0);
        chk("reset_c500", {31'd0, coin_500}, 32'd0);
        chk("reset_rej",  {31'd0, coin_rejected}, 32'd0);
    endtask

    task automatic run_trace(input logic [31:0] r100, input logic [31:0] r500,
                             input logic [31:0] lk, input logic [31:0] rs);
        for (int i = 0; i < 32; i++) begin
            coin_100_raw = r100[i];
            coin_500_raw = r500[i];
            lockout      = lk[i];
            reset        = rs[i];
            @(posedge clock);
            #1;
            t100[i] = coin_100;
            t500[i] = coin_500;
            trej[i] = coin_rejected;
        end
    endtask

    task automatic scenario(input string name,
                            input logic [31:0] r100, input logic [31:0] r500,
                            input logic [31:0] lk, input logic [31:0] rs,
                            input logic [31:0] e100, input logic [31:0] e500,
                            input logic [31:0] erej);
        reset_dut();
        run_trace(r100, r500, lk, rs);
        chk({name, "_c100"}, t100, e100);
        chk({name, "_c500"}, t500, e500);
        chk({name, "_rej"},  trej, erej);
        chk({name, "_onehot"}, (t100 & t500) | (t100 & trej) | (t500 & trej), 32'd0);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        coin_100_raw = 1'b0;
        coin_500_raw = 1'b0;
        lockout      = 1'b0;

        // Clean 20-cycle press: single pulse after edge 6, none on release.
        scenario("clean", 32'h000F_FFFF, 32'h0, 32'h0, 32'h0,
                 32'h0000_0040, 32'h0, 32'h0);
        // Bounce 1,0,1,0 then steady from edge 4: pulse after edge 10.
        scenario("bounce", 32'h0, 32'hFFFF_FFF5, 32'h0, 32'h0,
                 32'h0, 32'h0000_0400, 32'h0);
        // 3-cycle glitch gives nothing; later press from edge 10 pulses at 16.
        scenario("glitch", 32'hFFFF_FC07, 32'h0, 32'h0, 32'h0,
                 32'h0001_0000, 32'h0, 32'h0);
        // Simultaneous press; lockout rising at edge 7 must not cancel the 100.
        scenario("simul", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FF80, 32'h0,
                 32'h0000_0080, 32'h0000_0040, 32'h0);
        // Locked press rejected at 6; release, re-press at 17 accepted at 23.
        scenario("lockout", 32'h0, 32'hFFFE_03FF, 32'h0000_03FF, 32'h0,
                 32'h0, 32'h0080_0000, 32'h0000_0040);
        // Both rejected on the same edge: two consecutive reject pulses.
        scenario("dualrej", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,
                 32'h0, 32'h0, 32'h0000_00C0);
        // Reset at edge 4 aborts; held button re-qualifies after edge 11.
        scenario("midreset", 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0010,
                 32'h0000_0800, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_input_module.md
Name: coin_input_module

Overview:
- Front-end conditioning stage for the two coin pushbuttons, sitting directly upstream of coin_counter_module.
- Synchronises and debounces the raw board inputs. Emits exactly one single-cycle pulse per physical press on coin_100 / coin_500, which coin_counter_module consumes.
- Arbitrates simultaneous presses and rejects coins while the dispense FSM is busy, so credit is never double-counted or silently lost.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a press or a release (4 for simulation; 500000 on the 50 MHz board).
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, width of the debounce counters (derived; do not override).

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- coin_100_raw  input  1  asynchronous pushbutton, 1 = pressed.
- coin_500_raw  input  1  asynchronous pushbutton, 1 = pressed.
- lockout  input  1  1 = machine dispensing; driven by fsm_module (high while not idle).
- coin_100  output  1  one-cycle pulse, one accepted 100 coin.
- coin_500  output  1  one-cycle pulse, one accepted 500 coin.
- coin_rejected  output  1  one-cycle pulse, press accepted by the debouncer but refused because of lockout.

Behaviour:
- Reset: all outputs 0. Synchronisers 0, both channels in IDLE, counters 0, pending flag 0. Reset mid-debounce aborts the press without a pulse. A button still held when reset deasserts is treated as a new press.
- Synchronisation: 2-flop synchroniser per raw input (s1 then s2). Only s2 is used downstream.
- Per-channel FSM (states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT):
  - IDLE: s2=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: s2=0 -> IDLE (glitch, no pulse). s2=1 and cnt=DEBOUNCE_CYCLES-1 -> HELD and raise "qualified" for this edge. Otherwise cnt+1.
  - HELD: s2=0 -> RELEASE_WAIT, cnt=0. There is no auto-repeat, however long the button is held.
  - RELEASE_WAIT: s2=1 -> HELD (bounce on release). s2=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt+1.
- Latency: raw held high from before edge 0 gives s2=1 after edge 1, PRESS_WAIT after edge 2, and HELD plus pulse after edge 2+DEBOUNCE_CYCLES. The pulse is high for exactly one cycle.
- Pulses are registered outputs. At most one of coin_100, coin_500, coin_rejected is high in any cycle.
- Lockout is sampled on the qualifying edge:
  - lockout=1: coin_rejected pulses and no coin pulse is issued.
  - lockout=0: the coin pulse is issued.
- Simultaneous qualification (both channels on the same edge, lockout=0): coin_500 pulses first. coin_100 is held in the pending flag and pulses on the next edge. The pending coin is already accepted, so lockout rising in between does not cancel it.
- Same-edge rejection on both channels: coin_rejected pulses on two consecutive cycles, using the same pending mechanism.
- A new qualification on a channel whose pending flag is still set cannot occur, because the minimum press-to-press spacing is at least 2*DEBOUNCE_CYCLES+1 cycles.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1. No wrap-around is allowed.

Decomposition:
- Package coin_input_pkg:
  - typedef enum logic [1:0] debounce_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - typedef enum logic [1:0] coin_event_t {EV_NONE, EV_100, EV_500, EV_REJECT};
  - default DEBOUNCE_CYCLES constant.
- Sub-module button_debouncer_module (synchroniser, channel FSM and counter; output qualified). It is instantiated twice.
- The arbitration, pending flag and output registers live in the top module.

Test Plan (DEBOUNCE_CYCLES=4; edges numbered from stimulus start):
- Clean press: coin_100_raw=1 before edge 0, held 20 cycles, lockout=0 -> coin_100 high only in the cycle after edge 6. No further pulse while held or on release.
- Bouncing press: coin_500_raw toggles 1,0,1,0 on successive cycles, then stays 1 -> no pulse during the bounce. Exactly one coin_500 pulse 6 edges after the final rising transition.
- Short glitch: coin_100_raw high for 3 cycles, then 0 -> no output pulse at any time. Channel returns to IDLE.
- Simultaneous press: both raw inputs rise before edge 0 -> coin_500 pulses after edge 6 and coin_100 pulses after edge 7. Never both in one cycle.
- Lockout: lockout=1 and coin_500_raw pressed -> coin_rejected pulses after edge 6 and coin_500 stays 0. Then lockout=0 with a release and re-press -> one coin_500 pulse.
- Reset mid-operation: coin_100_raw high, reset=1 at edge 4 for 1 cycle -> no pulse around the reset. Button still held gives one coin_100 pulse 6 edges after reset deasserts.
